// File: rtl/periph_timer.sv
// Memory-mapped timer/LED/switch/7-seg/tick peripheral at 0x40000000
// for the single-cycle MIPS data bus; combinational reads, clocked writes.
module periph_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [11:0] digi
);

    typedef enum logic [2:0] {
        R_TH   = 3'd0,
        R_TL   = 3'd1,
        R_TCON = 3'd2,
        R_LED  = 3'd3,
        R_SW   = 3'd4,
        R_DIGI = 3'd5,
        R_TICK = 3'd6,
        R_RSVD = 3'd7
    } reg_e;

    localparam logic [26:0] BASE_HI = 27'h2000000;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [31:0] tick_q;

    logic sel;
    logic we;
    logic ovf;
    reg_e idx;

    assign sel = (addr[31:5] == BASE_HI);
    assign idx = reg_e'(addr[4:2]);
    assign we  = wr & sel;
    assign ovf = tcon_q[0] & (tl_q == 32'hFFFF_FFFF);

    always_comb begin
        rdata = '0;
        if (rd && sel) begin
            unique case (idx)
                R_TH:   rdata = th_q;
                R_TL:   rdata = tl_q;
                R_TCON: rdata = {29'd0, tcon_q};
                R_LED:  rdata = {24'd0, led_q};
                R_SW:   rdata = {24'd0, switch};
                R_DIGI: rdata = {20'd0, digi_q};
                R_TICK: rdata = tick_q;
                R_RSVD: rdata = '0;
            endcase
        end
    end

    // Reload always takes the pre-write TH; a TL write beats the count.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        digi_d = digi_q;
        if (tcon_q[0]) begin
            tl_d = ovf ? th_q : tl_q + 32'd1;
        end
        if (we) begin
            unique case (idx)
                R_TH:   th_d   = wdata;
                R_TL:   tl_d   = wdata;
                R_TCON: tcon_d = wdata[2:0];
                R_LED:  led_d  = wdata[7:0];
                R_DIGI: digi_d = wdata[11:0];
                R_SW, R_TICK, R_RSVD: ;
            endcase
        end
        // Overflow status wins over a same-cycle TCON write.
        if (ovf && tcon_q[1]) begin
            tcon_d[2] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            led_q  <= '0;
            digi_q <= '0;
            tick_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            digi_q <= digi_d;
            tick_q <= tick_q + 32'd1;
        end
    end

    assign irq  = tcon_q[1] & tcon_q[2];
    assign led  = led_q;
    assign digi = digi_q;

endmodule

// File: tb/tb_periph_timer.sv
// Directed bench for periph_timer: stimulus queues expectations,
// a negedge monitor pops and compares them against DUT outputs.
module tb_periph_timer;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_TICK = 32'h4000_0018;
  localparam logic [31:0] A_RSVD = 32'h4000_001C;

  localparam int K_RD   = 0;
  localparam int K_IRQ  = 1;
  localparam int K_LED  = 2;
  localparam int K_DIGI = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   rel = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  periph_timer dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .rd     (rd),
    .wr     (wr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq),
    .switch (switch),
    .led    (led),
    .digi   (digi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] got;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      case (e.kind)
        K_RD:    got = rdata;
        K_IRQ:   got = {31'd0, irq};
        K_LED:   got = {24'd0, led};
        default: got = {20'd0, digi};
      endcase
      n_chk++;
      if (e.cyc != cyc || got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (cycle %0d/%0d)",
                 e.name, got, e.exp, cyc, e.cyc);
      end
    end
  end

  task automatic expect_v(int k, logic [31:0] v, string nm);
    exp_t e;
    e.cyc  = cyc;
    e.kind = k;
    e.exp  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic wreg(logic [31:0] a, logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    step();
  endtask

  task automatic rchk(logic [31:0] a, logic [31:0] v, string nm);
    addr = a;
    rd   = 1'b1;
    expect_v(K_RD, v, nm);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    addr   = '0;
    wdata  = '0;
    switch = 8'h5A;
    step();

    for (int i = 0; i < 6; i++) begin
      addr  = A_TH | ($urandom_range(0, 31));
      wdata = $urandom;
      wr    = 1'b1;
      if (i == 5) begin
        expect_v(K_IRQ, 32'd0, "rst_irq");
        expect_v(K_LED, 32'd0, "rst_led");
        expect_v(K_DIGI, 32'd0, "rst_digi");
      end
      step();
    end
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL d_rst_irq: got %b expected 0", irq);
    end
    n_chk++;
    if (led !== 8'd0) begin
      n_fail++;
      $display("FAIL d_rst_led: got %h expected 00", led);
    end
    n_chk++;
    if (digi !== 12'd0) begin
      n_fail++;
      $display("FAIL d_rst_digi: got %h expected 000", digi);
    end
    for (int i = 0; i < 8; i++) begin
      wr    = 1'b1;
      wdata = $urandom;
      rchk(A_TH + 32'(i * 4), (i == 4) ? 32'h5A : 32'd0, "rst_read");
    end

    reset = 1'b1;
    rel   = cyc;
    rchk(A_TICK, 32'd0, "tick_first");
    rchk(A_TICK, 32'd1, "tick_second");

    wreg(A_TH, 32'hFFFF_FFFD);
    wreg(A_TL, 32'hFFFF_FFFE);
    wreg(A_TCON, 32'd3);
    rchk(A_TCON, 32'd3, "tcon_on");
    expect_v(K_IRQ, 32'd0, "irq_pre");
    rchk(A_TL, 32'hFFFF_FFFF, "tl_ff");
    expect_v(K_IRQ, 32'd1, "irq_ovf");
    rchk(A_TL, 32'hFFFF_FFFD, "tl_reload");
    rchk(A_TCON, 32'd7, "tcon_7");
    rchk(A_TL, 32'hFFFF_FFFF, "tl_ff2");
    expect_v(K_IRQ, 32'd1, "irq_hold");
    rchk(A_TL, 32'hFFFF_FFFD, "tl_reload2");

    wreg(A_TCON, 32'd1);
    expect_v(K_IRQ, 32'd0, "irq_ack");
    rchk(A_TL, 32'hFFFF_FFFF, "tl_after_ack");
    rchk(A_TCON, 32'd1, "tcon_no_ie");
    wreg(A_TCON, 32'd3);
    expect_v(K_IRQ, 32'd0, "irq_armed");
    wreg(A_TCON, 32'd1);
    expect_v(K_IRQ, 32'd0, "irq_ack_ovf");
    rchk(A_TCON, 32'd5, "tcon_keep_sts");
    rchk(A_TL, 32'hFFFF_FFFE, "tl_counting");

    wreg(A_TCON, 32'd0);
    wreg(A_TL, 32'd5);
    for (int i = 0; i < 10; i++) begin
      rchk(A_TL, 32'd5, "tl_hold");
    end
    wreg(A_TCON, 32'd1);
    wreg(A_TL, 32'h1234_5678);
    rchk(A_TL, 32'h1234_5678, "tl_wr");
    rchk(A_TL, 32'h1234_5679, "tl_wr_inc");

    wreg(A_TCON, 32'd0);
    wreg(A_LED, 32'h1A5);
    n_chk++;
    if (led !== 8'hA5) begin
      n_fail++;
      $display("FAIL d_led: got %h expected a5", led);
    end
    expect_v(K_LED, 32'hA5, "led_out");
    rchk(A_LED, 32'hA5, "led_rd");
    wreg(A_DIGI, 32'hFFFF_0E8E);
    n_chk++;
    if (digi !== 12'hE8E) begin
      n_fail++;
      $display("FAIL d_digi: got %h expected e8e", digi);
    end
    expect_v(K_DIGI, 32'hE8E, "digi_out");
    rchk(A_DIGI, 32'hE8E, "digi_rd");
    switch = 8'h3C;
    rchk(A_SW, 32'h3C, "sw_rd");
    wreg(A_SW, 32'hFF);
    wreg(A_TICK, 32'd0);
    rchk(A_TICK, 32'(cyc - rel), "tick_ro");
    wreg(A_RSVD, 32'hFFFF_FFFF);
    rchk(A_RSVD, 32'd0, "rsvd_rd");
    rchk(A_SW, 32'h3C, "sw_ro");
    rchk(A_TH, 32'hFFFF_FFFD, "th_kept");
    rchk(A_LED, 32'hA5, "led_kept");
    rchk(A_TCON, 32'd0, "tcon_kept");
    rchk(A_DIGI, 32'hE8E, "digi_kept");
    rchk(32'h4000_0020, 32'd0, "undec_hi");
    rchk(32'h5000_0004, 32'd0, "undec_base");
    addr = A_TH;
    expect_v(K_RD, 32'd0, "rd_low");
    step();

    wreg(32'h4000_0007, 32'hCAFE_F00D);
    rchk(A_TL, 32'hCAFE_F00D, "alias_wr");
    rchk(32'h4000_0006, 32'hCAFE_F00D, "alias_rd");

    force dut.tick_q = 32'hFFFF_FFFE;
    addr = A_TICK;
    rd   = 1'b1;
    expect_v(K_RD, 32'hFFFF_FFFE, "tick_fe");
    #2 release dut.tick_q;
    step();
    rchk(A_TICK, 32'hFFFF_FFFF, "tick_ff");
    rchk(A_TICK, 32'd0, "tick_wrap");

    wreg(A_TCON, 32'd6);
    expect_v(K_IRQ, 32'd1, "irq_sw_set");
    step();
    reset = 1'b0;
    expect_v(K_IRQ, 32'd0, "irq_async_rst");
    expect_v(K_LED, 32'd0, "led_async_rst");
    rchk(A_TL, 32'd0, "tl_async_rst");
    reset = 1'b1;

    repeat (3) step();
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: got unchecked expected checked", e.name);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_timer.md
# periph_timer

Memory-mapped peripheral slave at base 0x40000000 on the single-cycle MIPS CPU data bus. It provides a reloadable 32-bit interval timer that raises the CPU interrupt request, plus an LED register, a switch input, a 7-segment digit register and a free-running system tick counter. The boot and interrupt code in instruction ROM configures the timer through this block. It acknowledges interrupts by clearing TCON bits. It drives digits and LEDs through this block.

## Interface
- No parameters; base address 0x40000000 and the register map are fixed.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- addr  input  32  byte address from CPU ALU result.
- rd  input  1  MemRead strobe.
- wr  input  1  MemWrite strobe.
- wdata  input  32  store data.
- rdata  output  32  load data, combinational.
- irq  output  1  interrupt request to CPU control unit.
- switch  input  8  board switches.
- led  output  8  LED register.
- digi  output  12  7-segment drive: [11:8] digit anode select, [7:0] segment pattern.

## Operation
- Decode: selected when addr[31:5] == 0x40000000 >> 5. The register is addr[4:2]. addr[1:0] are ignored.
- Register map:
  - 0x00 TH (rw, 32): reload value.
  - 0x04 TL (rw, 32): count.
  - 0x08 TCON (rw, [2:0]): bit0 enable, bit1 interrupt enable, bit2 interrupt status. Bits [31:3] read 0.
  - 0x0C LED (rw, [7:0]).
  - 0x10 SWITCH (ro, [7:0]); writes ignored.
  - 0x14 DIGI (rw, [11:0]).
  - 0x18 SYSTICK (ro, 32); writes ignored.
  - 0x1C reserved: reads 0, writes ignored.
- Read path: rdata = selected register, zero-extended, when rd=1 and the address decodes. Otherwise rdata = 0. Reads have no side effects.
- Write path: when wr=1 and the address decodes, the addressed register takes wdata (truncated to its width) at the clock edge.
- Timer counting, when TCON[0]=1, each cycle:
  - If TL == 0xFFFFFFFF: TL <= TH. If TCON[1]=1, TCON[2] <= 1.
  - Otherwise TL <= TL + 1 (32-bit, modulo).
  - When TCON[0]=0, TL holds its value.
- Priority and simultaneous events:
  - A CPU write to TL overrides the count/reload in that cycle.
  - A CPU write to TH in the reload cycle: the reload uses the old TH. The new TH applies to the next reload.
  - A CPU write to TCON takes the written bits. Exception: if an overflow with pre-write TCON[0]=TCON[1]=1 occurs in the same cycle, TCON[2] ends at 1, so no interrupt is lost.
  - Enable/interrupt-enable decisions in a cycle use the pre-write TCON values.
- irq = TCON[1] & TCON[2], driven from registered state with no combinational path from inputs.
  - irq stays asserted until software clears bit1 or bit2.
  - Writing 1 to TCON[2] sets the status; it is software-settable.
- SYSTICK increments every cycle from reset and wraps 0xFFFFFFFF -> 0.
- SWITCH is passed through combinationally on read; no synchronizer in this block.

## Timing
- Reset (async, reset=0) forces TH, TL, TCON, LED, DIGI and SYSTICK to 0. As a result irq=0, led=0 and digi=0 during reset and immediately after it.
- Read latency: 0 cycles (same-cycle combinational, as the single-cycle CPU requires).
- Write latency: the value is visible on rdata and outputs in the cycle after the edge where wr=1.
- Overflow to irq: TL == 0xFFFFFFFF at edge N gives TL=TH and irq=1 after edge N. The CPU samples irq at the next instruction boundary.
- Interrupt period with a constant TH: exactly 0x100000000 - TH cycles between consecutive status sets.
- Reset asserted mid-count clears the count and any pending irq immediately; there is no partial state.

## Test plan
- Reset: hold reset=0 with wr=1 and random addr/wdata -> all reads return 0 except SWITCH. irq=0, led=0, digi=0. SYSTICK reads 0 in the first cycle after release and 1 in the next.
- Reload/IRQ:
  - Stimulus: write TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3.
  - Required response: TL=0xFFFFFFFF after one edge; after the next edge TL=0xFFFFFFFD, TCON=7, irq=1.
  - Continue: after 3 more edges TL returns to 0xFFFFFFFD.
- Ack: with irq=1, write TCON=TCON&0xFFFFFFF9 (i.e. 1) -> irq=0 next cycle and TL keeps counting. Set up overflow in that same write cycle -> TCON[2] reads 1 and irq=0, because bit1 is cleared.
- Disable: TCON=0 with TL=5 -> TL reads 5 across 10 cycles. Write TL=0x12345678 while TCON=1 -> next cycle TL=0x12345678, then 0x12345679.
- Map/decode:
  - Write LED=0x1A5 -> led=0xA5. Write DIGI=0xFFFF0E8E -> digi=0xE8E.
  - switch=0x3C -> read 0x40000010 = 0x0000003C.
  - Writes to 0x10, 0x18 and 0x1C have no effect. Reads of 0x40000020 and 0x50000004 return 0.
  - Address 0x40000007 aliases TL.
- SYSTICK wrap: force SYSTICK near 0xFFFFFFFE via a long run or backdoor -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on consecutive cycles.
